// File: rtl/pixel_stream_feeder.sv
// Frame buffer plus raster-order streamer toward the CNN pixel input.
// Sync-read RAM feeds a 2-entry output stage (head register + skid) under ready_in backpressure.
module pixel_stream_feeder #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              ready_in,
    output logic [DATA_W-1:0] pixel_out,
    output logic              valid_out,
    output logic              busy,
    output logic              done,
    output logic              load_err,
    output logic [ADDR_W-1:0] sent_cnt
);
    localparam int                N      = IMG_W * IMG_H;
    localparam logic [ADDR_W:0]   N_W    = (ADDR_W+1)'(N);
    localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
    state_t state, state_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data, skid;
    logic              rd_vld, skid_vld;
    logic [ADDR_W:0]   rd_idx;
    logic              busy_w, start_ok, addr_bad, wr_ok, pop, last_pop, can_issue, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        occ;

    // done cycle still counts as busy, so a start landing on it is ignored
    assign busy_w    = (state != IDLE) || done;
    assign busy      = busy_w;
    assign start_ok  = start && !busy_w;
    assign addr_bad  = {1'b0, load_addr} >= N_W;
    assign wr_ok     = load_en && !busy_w && !addr_bad;
    assign pop       = valid_out && ready_in;
    assign last_pop  = pop && (sent_cnt == LAST_W);
    // slots committed after this edge: head + skid + read in flight - leaving pixel
    assign occ       = {1'b0, valid_out} + {1'b0, skid_vld} + {1'b0, rd_vld} - {1'b0, pop};
    assign can_issue = occ <= 2'd1;
    assign rd_en     = start_ok || ((state != IDLE) && (rd_idx < N_W) && can_issue);
    assign rd_addr   = start_ok ? '0 : rd_idx[ADDR_W-1:0];

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_ok) state_d = FILL;
            FILL:    state_d = STREAM;
            STREAM:  if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // write forwarding lets a same-cycle load+start stream the fresh value
    always_ff @(posedge clk) begin
        if (wr_ok) mem[load_addr] <= load_data;
        if (rd_en) rd_data <= (wr_ok && load_addr == rd_addr) ? load_data : mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            pixel_out <= '0;
            skid      <= '0;
            skid_vld  <= 1'b0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            sent_cnt  <= '0;
            done      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state    <= state_d;
            done     <= last_pop;
            load_err <= load_en && (busy_w || addr_bad);
            rd_vld   <= rd_en;
            if (start_ok)   rd_idx <= (ADDR_W+1)'(1);
            else if (rd_en) rd_idx <= rd_idx + 1'b1;
            if (start_ok)   sent_cnt <= '0;
            else if (pop)   sent_cnt <= sent_cnt + 1'b1;
            // skid is only ever occupied while the head is valid
            if (pop) begin
                if (skid_vld) begin
                    pixel_out <= skid;
                    valid_out <= 1'b1;
                    if (rd_vld) skid <= rd_data;
                    skid_vld  <= rd_vld;
                end else begin
                    valid_out <= rd_vld;
                    if (rd_vld) pixel_out <= rd_data;
                end
            end else if (!valid_out) begin
                valid_out <= rd_vld;
                if (rd_vld) pixel_out <= rd_data;
            end else if (rd_vld) begin
                skid     <= rd_data;
                skid_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Randomized bench for pixel_stream_feeder against a frame-array / ordered-index model.
module tb_pixel_stream_feeder;
    localparam int N = 28 * 28;

    logic        clk = 1'b0;
    logic        reset, load_en, start, ready_in;
    logic [9:0]  load_addr;
    logic [15:0] load_data, pixel_out;
    logic        valid_out, busy, done, load_err;
    logic [9:0]  sent_cnt;

    logic [15:0] ref_mem [N];
    int checks = 0;
    int errors = 0;

    pixel_stream_feeder dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .ready_in(ready_in),
        .pixel_out(pixel_out), .valid_out(valid_out), .busy(busy), .done(done),
        .load_err(load_err), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_px(input int a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a[9:0];
        load_data = d;
        step();
        load_en = 1'b0;
        chk("load_err", int'(load_err), (a >= N) ? 1 : 0);
        if (a < N) ref_mem[a] = d;
    endtask

    // rmode 0: always ready, 1: random 50%, 2: 20-cycle stall at pixel 100
    task automatic stream_frame(input int rmode, input int abort_at, input int poke_at);
        int cyc, idx, first, stall;
        bit r, prev_hold, poked, poke_chk, done_seen;
        logic [15:0] prev_px;
        start    = 1'b1;
        ready_in = 1'b1;
        step();
        start   = 1'b0;
        load_en = 1'b0;
        chk("busy_fill", int'(busy), 1);
        chk("cnt_clr", int'(sent_cnt), 0);
        chk("v_fill", int'(valid_out), 0);
        chk("lerr_start", int'(load_err), 0);
        cyc = 1; idx = 0; first = -1; stall = 0;
        prev_hold = 0; poked = 0; poke_chk = 0; done_seen = 0; prev_px = '0;
        for (int guard = 0; guard < 20000; guard++) begin
            if (poke_chk) begin
                chk("poke_err", int'(load_err), 1);
                poke_chk = 0;
            end
            if (prev_hold) begin
                chk("hold_v", int'(valid_out), 1);
                chk("hold_px", int'(pixel_out), int'(prev_px));
            end
            if (done) begin
                chk("done_n", idx, N);
                chk("done_cnt", int'(sent_cnt), N);
                chk("busy_done", int'(busy), 1);
                if (rmode == 0) chk("done_cyc", cyc, N + 2);
                done_seen = 1;
                break;
            end
            chk("busy", int'(busy), 1);
            chk("cnt", int'(sent_cnt), idx);
            if (valid_out && first < 0) first = cyc;
            if (abort_at >= 0 && idx == abort_at) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                chk("ab_valid", int'(valid_out), 0);
                chk("ab_busy", int'(busy), 0);
                chk("ab_cnt", int'(sent_cnt), 0);
                for (int k = 0; k < 8; k++) begin
                    step();
                    chk("ab_done", int'(done), 0);
                end
                return;
            end
            case (rmode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: begin
                    r = !(idx == 100 && stall < 20);
                    if (!r) stall++;
                end
            endcase
            if (poke_at >= 0 && !poked && idx == poke_at) begin
                load_en   = 1'b1;
                load_addr = 10'd5;
                load_data = ~ref_mem[5];
                start     = 1'b1;
                poked     = 1;
                poke_chk  = 1;
            end else begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            ready_in  = r;
            prev_hold = valid_out && !r;
            prev_px   = pixel_out;
            if (valid_out && r) begin
                if (idx < N) chk("px", int'(pixel_out), int'(ref_mem[idx]));
                else chk("extra_px", idx, N - 1);
                idx++;
            end
            step();
            cyc++;
        end
        load_en = 1'b0;
        start   = 1'b0;
        if (!done_seen) chk("timeout", 0, 1);
        chk("first_lat", first, 2);
        if (rmode == 2) chk("stall_len", stall, 20);
        ready_in = 1'b1;
        step();
        chk("busy_off", int'(busy), 0);
        chk("done_pulse", int'(done), 0);
        chk("cnt_hold", int'(sent_cnt), N);
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; start = 1'b0; ready_in = 1'b0;
        load_addr = '0; load_data = '0;
        repeat (3) step();
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lerr", int'(load_err), 0);
        chk("rst_px", int'(pixel_out), 0);
        chk("rst_cnt", int'(sent_cnt), 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < N; i++) load_px(i, 16'(i));
        stream_frame(0, -1, -1);
        stream_frame(1, -1, -1);
        stream_frame(2, -1, -1);

        // write and start during the stream must both be ignored
        stream_frame(0, -1, 50);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("no_restart_busy", int'(busy), 0);
            chk("no_2nd_done", int'(done), 0);
        end
        load_px(800, 16'h1111);
        stream_frame(0, -1, -1);

        for (int i = 0; i < N; i++) load_px(i, 16'($urandom));
        stream_frame(1, 300, -1);
        stream_frame(1, -1, -1);

        stream_frame(0, -1, -1);
        stream_frame(0, -1, -1);

        // load and start in the same idle cycle
        load_en   = 1'b1;
        load_addr = 10'd0;
        load_data = 16'hBEEF;
        ref_mem[0] = 16'hBEEF;
        stream_frame(1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
